pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and the instruction-fetch handshake to instruction memory.
- Presents each fetched instruction, with a valid strobe, to the instruction decoders.
- During the execute cycle, consumes the PC fields of the decoders' 31-bit control word and their 64-bit constant to compute the next PC.
- Drives the return address (PC+4) onto the data bus when the control word enables it.

Parameters:
RESET_VECTOR, 64'h0, PC value loaded on reset; must be word-aligned.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  64  fetch address; equals pc.
- imem_ack  input  1  instruction memory response valid.
- imem_data  input  32  instruction word; sampled when imem_ack=1 in FETCH.
- instruction  output  32  captured instruction register, fed to the decoders.
- instruction_valid  output  1  high for every cycle in EXECUTE.
- controlword  input  31  decoder control word.
- constant  input  64  decoder sign-extended constant.
- databus_in  input  64  data bus value; absolute-target source.
- stall  input  1  holds EXECUTE; no PC update while high.
- pc  output  64  current program counter.
- databus_out  output  64  return address, PC+4.
- databus_oe  output  1  data bus drive enable.
- halted  output  1  sticky misalignment halt.

Behaviour:
- Control word fields consumed (all others ignored):
  - bit 4: databus_program_counter_enable
  - bits 3:2: program_counter_function_select
  - bit 1: program_counter_input_select (0 = databus_in, 1 = constant)
- Reset, asynchronous on reset_n low; every output is held at its reset value while reset_n is low:
  - pc = RESET_VECTOR, instruction = 0, state = IDLE.
  - imem_req = 0, instruction_valid = 0, databus_oe = 0, databus_out = 0, halted = 0.
- State IDLE: one cycle after reset release, then go to FETCH.
- State FETCH:
  - imem_req = 1; imem_addr = pc, stable for the whole state.
  - On an edge with imem_ack = 1: instruction <= imem_data, go to EXECUTE.
  - An ack in the first request cycle is legal. imem_ack outside FETCH is ignored.
- State EXECUTE:
  - instruction_valid = 1.
  - databus_oe = controlword[4]; databus_out = pc + 4.
  - If stall = 1: stay in EXECUTE, all registers hold.
  - If stall = 0: compute next PC from fs = controlword[3:2] and src = (controlword[1] ? constant : databus_in):
    - 00: hold pc
    - 01: pc + 4
    - 10: src (absolute)
    - 11: pc + (src << 2)
- Arithmetic: all additions are 64-bit modulo 2^64 with wrap-around and no overflow flag; the shift discards bits 63:62 of src.
- Misalignment: if next PC[1:0] != 0, pc is not updated, halted <= 1, go to HALT. Otherwise pc <= next PC and go to FETCH.
- State HALT:
  - Terminal until reset; imem_req = 0, instruction_valid = 0, databus_oe = 0.
  - pc and instruction keep their last values.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate ack, then EXECUTE). Each wait cycle on imem_ack or stall adds one cycle.
- A stall input outside EXECUTE has no effect.
- Reset asserted mid-FETCH or mid-EXECUTE: imem_req drops immediately (asynchronous) and the pending fetch is abandoned. Memory must tolerate a withdrawn request.
- databus_oe and instruction_valid are registered-state decodes; no combinational path from imem_ack to them.

Test Plan:
- Reset then sequential fetch: RESET_VECTOR = 0x100, imem_ack tied high, controlword = 0x04 (fs = 01) -> imem_addr sequence 0x100, 0x104, 0x108, one instruction every 2 cycles; instruction_valid alternates 0/1.
- Branch with negative offset: pc = 0x100, controlword = 0x1E, constant = 64'hFFFF_FFFF_FFFF_FFFF -> databus_oe = 1 with databus_out = 0x104 in EXECUTE; next imem_addr = 0xFC.
- Absolute load plus misalignment: controlword = 0x08 (fs = 10, src = databus); databus_in = 0x2000 -> pc = 0x2000. Then databus_in = 0x2002 -> halted = 1, imem_req stays 0, pc stays 0x2000.
- Wait states and stall: imem_ack delayed 3 cycles -> imem_addr stable and instruction unchanged until ack. Then stall high for 2 EXECUTE cycles -> instruction_valid high 3 cycles, pc unchanged until stall drops.
- Wrap-around: pc = 0xFFFF_FFFF_FFFF_FFFC with fs = 01 -> next pc = 0x0, halted stays 0.
- Async reset mid-FETCH: reset_n low while imem_req = 1 -> imem_req = 0 within the same cycle; after release, pc = RESET_VECTOR and first request in the 2nd cycle.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Program counter owner and instruction-fetch sequencer; fetches
//               a word, presents it for one or more execute cycles, then
//               computes the next PC from the decoder control word.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  input  logic [30:0] controlword,
  input  logic [63:0] constant,
  input  logic [63:0] databus_in,
  input  logic        stall,
  output logic [63:0] pc,
  output logic [63:0] databus_out,
  output logic        databus_oe,
  output logic        halted
);

  localparam logic [63:0] c_PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pc;
  logic [31:0] r_instruction;
  logic        r_halted;

  logic [63:0] w_src;
  logic [63:0] w_next_pc;
  logic [63:0] w_pc_plus4;
  logic        w_misaligned;
  logic        w_pc_load;
  logic        w_instr_load;
  logic        w_halt_set;
  logic        w_unused_cw;

  // Only the PC-related fields of the control word matter here.
  assign w_unused_cw = ^{controlword[30:5], controlword[0]};

  assign w_pc_plus4 = r_pc + c_PC_STEP;
  assign w_src      = controlword[1] ? constant : databus_in;

  always_comb begin
    w_next_pc = r_pc;
    case (controlword[3:2])
      2'b00:   w_next_pc = r_pc;
      2'b01:   w_next_pc = w_pc_plus4;
      2'b10:   w_next_pc = w_src;
      default: w_next_pc = r_pc + {w_src[61:0], 2'b00};
    endcase
  end

  assign w_misaligned = |w_next_pc[1:0];

  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_instr_load = 1'b0;
    w_halt_set   = 1'b0;
    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          w_instr_load = 1'b1;
          w_state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (!stall) begin
          if (w_misaligned) begin
            w_halt_set   = 1'b1;
            w_state_next = S_HALT;
          end else begin
            w_pc_load    = 1'b1;
            w_state_next = S_FETCH;
          end
        end
      end
      default: w_state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VECTOR;
      r_instruction <= 32'd0;
      r_halted      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_pc_load) begin
        r_pc <= w_next_pc;
      end
      if (w_instr_load) begin
        r_instruction <= imem_data;
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so reset forces them immediately.
  assign imem_req          = (r_state == S_FETCH);
  assign imem_addr         = r_pc;
  assign instruction       = r_instruction;
  assign instruction_valid = (r_state == S_EXECUTE);
  assign databus_oe        = instruction_valid & controlword[4];
  assign databus_out       = instruction_valid ? w_pc_plus4 : 64'd0;
  assign pc                = r_pc;
  assign halted            = r_halted;

endmodule
`default_nettype wire
